// File: rtl/up_core_n_if.sv
// Board-side bus for up_core_n: run/enter controls, IN data, program-load port and status outputs.
// The master side belongs to the board or bench; the slave side belongs to the core.
interface up_core_n_if #(
    parameter int DW = 8,
    parameter int AW = 5
);
    logic          Run;
    logic          Enter;
    logic [DW-1:0] Input;
    logic          ProgWr;
    logic [AW-1:0] ProgAddr;
    logic [DW-1:0] ProgData;
    logic [DW-1:0] Output;
    logic [AW-1:0] PCout;
    logic          Halt;
    logic          Busy;
    logic          Aeq0;
    logic          Apos;

    modport master (
        output Run, Enter, Input, ProgWr, ProgAddr, ProgData,
        input  Output, PCout, Halt, Busy, Aeq0, Apos
    );

    modport slave (
        input  Run, Enter, Input, ProgWr, ProgAddr, ProgData,
        output Output, PCout, Halt, Busy, Aeq0, Apos
    );
endinterface

// File: rtl/up_core_n.sv
// Self-sequencing accumulator CPU: IR/A/PC, 2^AW x DW RAM, add/sub, IDLE/FETCH/DECODE/EXEC/HALT control.
// Define UP_CORE_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module up_core_n #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic        CLOCK,
    input  logic        RESET,
    up_core_n_if.slave  bus
);
    localparam int DEPTH = 1 << AW;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] ir;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_nxt;
    logic [AW-1:0] pc;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rd;
    logic [DW-1:0] mem_wdata;

    logic [2:0]    opcode;
    logic [AW-1:0] field;

    logic          ir_ld;
    logic          pc_inc;
    logic          pc_jump;
    logic          pc_clr;
    logic          acc_ld;
    logic          mem_we;

    // Two's complement add/sub; optionally clamps to the signed range on overflow.
    function automatic logic [DW-1:0] addsub(input logic [DW-1:0] x,
                                             input logic [DW-1:0] y,
                                             input logic          sub);
`ifdef UP_CORE_SAT_EN
        logic signed [DW-1:0] sx;
        logic signed [DW-1:0] sy;
        logic signed [DW:0]   wide;
        sx = x;
        sy = y;
        if (sub)
            wide = $signed({sx[DW-1], sx}) - $signed({sy[DW-1], sy});
        else
            wide = $signed({sx[DW-1], sx}) + $signed({sy[DW-1], sy});
        if (wide[DW] != wide[DW-1])
            return wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return wide[DW-1:0];
`else
        logic signed [DW-1:0] sx;
        logic signed [DW-1:0] sy;
        sx = x;
        sy = y;
        return sub ? (sx - sy) : (sx + sy);
`endif
    endfunction

    assign opcode = ir[DW-1:DW-3];
    assign field  = ir[AW-1:0];

    always_comb begin
        case (state)
            S_DECODE, S_EXEC: ram_addr = field;
            S_IDLE:           ram_addr = bus.ProgAddr;
            default:          ram_addr = pc;
        endcase
    end

    assign ram_rd = mem[ram_addr];

    // Control: next state plus one-hot-ish register enables for the datapath.
    always_comb begin
        state_nxt = state;
        ir_ld     = 1'b0;
        pc_inc    = 1'b0;
        pc_jump   = 1'b0;
        pc_clr    = 1'b0;
        acc_ld    = 1'b0;
        acc_nxt   = acc;
        mem_we    = 1'b0;
        mem_wdata = acc;
        case (state)
            S_IDLE: begin
                mem_we    = bus.ProgWr;
                mem_wdata = bus.ProgData;
                if (bus.Run)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_ld     = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_LOAD: begin
                        acc_ld  = 1'b1;
                        acc_nxt = ram_rd;
                    end
                    OP_STORE: mem_we = 1'b1;
                    OP_ADD: begin
                        acc_ld  = 1'b1;
                        acc_nxt = addsub(acc, ram_rd, 1'b0);
                    end
                    OP_SUB: begin
                        acc_ld  = 1'b1;
                        acc_nxt = addsub(acc, ram_rd, 1'b1);
                    end
                    OP_IN: begin
                        if (bus.Enter) begin
                            acc_ld  = 1'b1;
                            acc_nxt = bus.Input;
                        end else begin
                            state_nxt = S_EXEC;
                        end
                    end
                    OP_JZ:   pc_jump = (acc == '0);
                    OP_JPOS: pc_jump = ~acc[DW-1];
                    default: ;
                endcase
            end
            S_HALT: begin
                if (!bus.Run) begin
                    pc_clr    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ir  <= '0;
            acc <= '0;
            pc  <= '0;
        end else begin
            if (ir_ld)
                ir <= ram_rd;
            if (acc_ld)
                acc <= acc_nxt;
            // A taken jump in EXEC replaces the increment already applied in FETCH.
            if (pc_clr)
                pc <= '0;
            else if (pc_jump)
                pc <= field;
            else if (pc_inc)
                pc <= pc + 1'b1;
        end
    end

    // RAM has no reset so program contents survive RESET; reset forces IDLE, cancelling any STORE.
    always_ff @(posedge CLOCK) begin
        if (mem_we)
            mem[ram_addr] <= mem_wdata;
    end

    assign bus.Output = acc;
    assign bus.PCout  = pc;
    assign bus.Halt   = (state == S_HALT);
    assign bus.Busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign bus.Aeq0   = (acc == '0);
    assign bus.Apos   = ~acc[DW-1];
endmodule

// File: tb/tb_up_core_n.sv
// Bench for up_core_n (DW=8, AW=5): directed programs plus random programs checked against an ISA-level model.
module tb_up_core_n;
    logic clk = 1'b0;
    logic rst = 1'b1;

    up_core_n_if #(.DW(8), .AW(5)) bus ();

    up_core_n #(.DW(8), .AW(5)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] img [32];
    logic [7:0] last_acc;
    logic [4:0] halt_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        bus.Run    = 1'b0;
        bus.ProgWr = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic load_image();
        for (int i = 0; i < 32; i++) begin
            bus.ProgAddr = 5'(i);
            bus.ProgData = img[i];
            bus.ProgWr   = 1'b1;
            tick(1);
        end
        bus.ProgWr = 1'b0;
    endtask

    task automatic clear_image();
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
    endtask

    // Signed DW-bit add/sub from integer arithmetic, clamped when saturation is built in.
    function automatic logic [7:0] arith(input logic [7:0] x, input logic [7:0] y, input bit sub);
        int r;
        r = sub ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
`ifdef UP_CORE_SAT_EN
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`endif
        return r[7:0];
    endfunction

    // Interpret the image one instruction at a time, checking the core after each one.
    task automatic run_program(input string name, input int max_instr);
        logic [7:0] m [32];
        logic [7:0] acc;
        logic [7:0] ir;
        logic [7:0] inval;
        logic [4:0] pc;
        logic [4:0] a;
        logic [2:0] op;
        bit         halted;
        for (int i = 0; i < 32; i++) m[i] = img[i];
        pulse_reset();
        load_image();
        acc = 8'h00;
        pc  = 5'd0;
        halted = 1'b0;
        bus.Enter = 1'b1;
        bus.Run   = 1'b1;
        tick(1);
        check({name, "_busy_start"}, 32'(bus.Busy), 32'd1);
        for (int n = 0; n < max_instr && !halted; n++) begin
            inval = 8'($urandom);
            bus.Input = inval;
            ir = m[pc];
            pc = pc + 5'd1;
            op = ir[7:5];
            a  = ir[4:0];
            case (op)
                3'd0: acc = m[a];
                3'd1: m[a] = acc;
                3'd2: acc = arith(acc, m[a], 1'b0);
                3'd3: acc = arith(acc, m[a], 1'b1);
                3'd4: acc = inval;
                3'd5: if (acc == 8'h00) pc = a;
                3'd6: if (!acc[7]) pc = a;
                default: halted = 1'b1;
            endcase
            if (halted) begin
                tick(2);
                halt_pc = bus.PCout;
                check({name, "_halt"},      32'(bus.Halt),   32'd1);
                check({name, "_halt_busy"}, 32'(bus.Busy),   32'd0);
                check({name, "_halt_pc"},   32'(bus.PCout),  32'(pc));
                check({name, "_halt_a"},    32'(bus.Output), 32'(acc));
            end else begin
                tick(3);
                check({name, "_a"},    32'(bus.Output), 32'(acc));
                check({name, "_pc"},   32'(bus.PCout),  32'(pc));
                check({name, "_busy"}, 32'(bus.Busy),   32'd1);
                check({name, "_aeq0"}, 32'(bus.Aeq0),   32'(acc == 8'h00));
                check({name, "_apos"}, 32'(bus.Apos),   32'(!acc[7]));
            end
        end
        bus.Run = 1'b0;
        if (halted) begin
            tick(1);
            check({name, "_idle_pc"},   32'(bus.PCout),  32'd0);
            check({name, "_idle_halt"}, 32'(bus.Halt),   32'd0);
            check({name, "_idle_a"},    32'(bus.Output), 32'(acc));
        end
        last_acc = acc;
        pulse_reset();
        for (int i = 0; i < 32; i++)
            check({name, "_mem"}, 32'(dut.mem[i]), 32'(m[i]));
    endtask

    initial begin
        bus.Run      = 1'b0;
        bus.Enter    = 1'b0;
        bus.Input    = 8'h00;
        bus.ProgWr   = 1'b0;
        bus.ProgAddr = 5'd0;
        bus.ProgData = 8'h00;
        halt_pc      = 5'd0;
        last_acc     = 8'h00;
        rst = 1'b1;
        tick(2);
        check("rst_output", 32'(bus.Output), 32'h0);
        check("rst_pc",     32'(bus.PCout),  32'h0);
        check("rst_halt",   32'(bus.Halt),   32'h0);
        check("rst_busy",   32'(bus.Busy),   32'h0);
        check("rst_aeq0",   32'(bus.Aeq0),   32'h1);
        check("rst_apos",   32'(bus.Apos),   32'h1);
        rst = 1'b0;
        tick(1);

        // Arithmetic program: LOAD 30, ADD 31, SUB 31, STORE 29, HALT.
        clear_image();
        img[0] = 8'h1E; img[1] = 8'h5F; img[2] = 8'h7F; img[3] = 8'h3D; img[4] = 8'hE0;
        img[30] = 8'h05; img[31] = 8'h03;
        run_program("arith", 10);
        check("arith_final_a", 32'(last_acc),    32'h05);
        check("arith_m29",     32'(dut.mem[29]), 32'h05);
        check("arith_halt_pc", 32'(halt_pc),     32'd5);

        // RESET during EXEC of a STORE must not write the target word.
        clear_image();
        img[0] = 8'h1E; img[1] = 8'h3C; img[2] = 8'hE0; img[28] = 8'h11; img[30] = 8'h33;
        pulse_reset();
        load_image();
        bus.Run = 1'b1;
        tick(1);
        check("store_busy", 32'(bus.Busy), 32'd1);
        tick(5);
        check("store_pre_a", 32'(bus.Output), 32'h33);
        bus.Run = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_output", 32'(bus.Output), 32'h0);
        check("abort_pc",     32'(bus.PCout),  32'h0);
        check("abort_halt",   32'(bus.Halt),   32'h0);
        check("abort_busy",   32'(bus.Busy),   32'h0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("abort_m28", 32'(dut.mem[28]), 32'h11);

        // IN handshake with a 10-cycle Enter wait; ProgWr in EXEC and HALT ignored.
        clear_image();
        img[0] = 8'h80; img[1] = 8'hE0; img[20] = 8'h44;
        pulse_reset();
        load_image();
        bus.Input = 8'h7A;
        bus.Enter = 1'b0;
        bus.Run   = 1'b1;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            bus.ProgWr   = (i == 3);
            bus.ProgAddr = 5'd20;
            bus.ProgData = 8'hFF;
            tick(1);
            check("in_wait_a",    32'(bus.Output), 32'h0);
            check("in_wait_busy", 32'(bus.Busy),   32'd1);
        end
        bus.ProgWr = 1'b0;
        bus.Enter  = 1'b1;
        tick(1);
        check("in_a", 32'(bus.Output), 32'h7A);
        bus.Enter = 1'b0;
        tick(2);
        check("in_halt",    32'(bus.Halt),  32'd1);
        check("in_halt_pc", 32'(bus.PCout), 32'd2);
        bus.ProgWr   = 1'b1;
        bus.ProgAddr = 5'd20;
        bus.ProgData = 8'h99;
        tick(1);
        bus.ProgWr = 1'b0;
        check("in_m20", 32'(dut.mem[20]), 32'h44);
        bus.Run = 1'b0;
        tick(1);
        check("in_idle_pc", 32'(bus.PCout),  32'd0);
        check("in_idle_a",  32'(bus.Output), 32'h7A);
        check("in_idle_busy", 32'(bus.Busy), 32'd0);

        // Branches: JZ taken, JPOS not taken on 0x80, JPOS taken on 0x01.
        clear_image();
        img[0]  = 8'h19; img[1]  = 8'hAA;
        img[10] = 8'h1A; img[11] = 8'hD4;
        img[12] = 8'h1B; img[13] = 8'hD0;
        img[16] = 8'hE0; img[20] = 8'hE0;
        img[25] = 8'h00; img[26] = 8'h80; img[27] = 8'h01;
        run_program("branch", 10);
        check("branch_halt_pc", 32'(halt_pc), 32'd17);

        // PC wrap 31->0 and signed overflow on ADD and SUB.
        clear_image();
        img[0] = 8'hA5; img[1] = 8'h3A; img[2] = 8'h1B; img[3] = 8'h7C; img[4] = 8'hE0;
        img[5] = 8'h1D; img[6] = 8'hDF; img[31] = 8'h5C;
        img[27] = 8'h80; img[28] = 8'h01; img[29] = 8'h7F;
        run_program("wrap", 12);
`ifdef UP_CORE_SAT_EN
        check("ovf_add", 32'(dut.mem[26]), 32'h7F);
        check("ovf_sub", 32'(last_acc),    32'h80);
`else
        check("ovf_add", 32'(dut.mem[26]), 32'h80);
        check("ovf_sub", 32'(last_acc),    32'h7F);
`endif

        // Random images; runaway loops are cut off after a bounded number of instructions.
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
            run_program("rand", 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
